calc_fsm_param: RTL and testbench
=================================

CALC_FSM_PARAM -- requirements
Module: calc_fsm_param

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning number of decimal digits per operand and result (range 2..8).
REQ-002 SHALL have derived constants MAXV = 10^DIGITS-1 and BW = ceil(log2(MAXV+1))+1, the two's-complement operand width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port reset_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port key_pressed, input, 1 bit: one-cycle strobe marking a valid key_code.
REQ-006 SHALL have port key_code, input, 4 bits: keypad code using the shared KEY_* constants.
REQ-007 SHALL have port display_bcd, output, 4*DIGITS bits: BCD magnitude shown, digit 0 in bits [3:0].
REQ-008 SHALL have port negative, output, 1 bit: displayed value is negative.
REQ-009 SHALL have port error, output, 1 bit: the calculator is in ERR state.
REQ-010 SHALL have port busy, output, 1 bit: a result conversion is in progress and keys are ignored.
REQ-011 SHALL have port state_out, output, 3 bits: current FSM state, for debug.

Function
REQ-012 SHALL decode keys: KEY_0..KEY_9 = digit, KEY_A = add, KEY_B = subtract, KEY_C = multiply, KEY_ASS = CE, KEY_HASH = equal; KEY_D and strobes while busy SHALL be ignored.
REQ-013 SHALL implement states NUM_INIT, LHS, NUM_RHS, RHS, CALC, RESULT, ERR.
REQ-014 SHALL hold each operand as a BW-bit binary value plus a DIGITS-digit BCD shadow and a digit count.
REQ-015 SHALL handle digit entry as follows: value = value*10+d and BCD shift-left-4 with d inserted; digits beyond DIGITS are ignored; leading zeros are not counted.
REQ-016 SHALL make these NUM_INIT transitions: digit -> LHS (lhs = d); op or equal -> stay.
REQ-017 SHALL make these LHS transitions: digit -> append; op -> NUM_RHS, latch op; equal -> RESULT with result = lhs.
REQ-018 SHALL make these NUM_RHS transitions: op -> replace latched op; digit -> RHS (rhs = d); equal -> RESULT with result = lhs.
REQ-019 SHALL make these RHS transitions: digit -> append; equal -> CALC; op -> CALC, then chain into NUM_RHS with lhs = result and the new op.
REQ-020 SHALL make these RESULT transitions: digit -> LHS (lhs = d, rhs cleared); op -> NUM_RHS with lhs = result; equal -> CALC repeating result op rhs.
REQ-021 SHALL in CALC compute r = lhs op rhs in 2*BW-bit signed arithmetic in cycle 1.
REQ-022 SHALL in CALC go to ERR if |r| > MAXV; otherwise it SHALL convert |r| with the converter, taking exactly BW cycles, then load result and enter RESULT.
REQ-023 SHALL assert busy from the cycle after the triggering key until the cycle RESULT or ERR is entered.
REQ-024 SHALL make ERR ignore every key except CE, and SHALL drive display_bcd all 4'hF with error=1.
REQ-025 SHALL make CE in any non-CALC state go to NUM_INIT, clearing lhs, rhs, result, op and flags.
REQ-026 SHALL make CE during CALC be ignored.
REQ-027 SHALL drive display from the registered active value: lhs in NUM_INIT/LHS/NUM_RHS, rhs in RHS, result in RESULT.
REQ-028 SHALL drive negative only for a negative result shown in RESULT.
REQ-029 SHALL register every output.

Reset
REQ-030 SHALL, on reset_in=1 at a clock edge, set state=NUM_INIT, operands, result and op=0, display_bcd=0, negative=0, error=0, busy=0.
REQ-031 SHALL let reset abort an in-progress conversion.

Structure
REQ-032 SHALL keep KEY_* codes, op encodings and state encodings in the shared constants header.
REQ-033 SHALL place the sequential binary-to-BCD converter (double-dabble, start/done handshake, parametrised by DIGITS) in sub-module bin2bcd_seq.

Verification
REQ-034 SHALL cover: 1,2,+,3,4,= -> display 0046, negative=0, busy high for exactly BW+1 cycles.
REQ-035 SHALL cover: 5,-,9,= -> display 0004, negative=1; then +,1,0,= -> display 0006, negative=0.
REQ-036 SHALL cover: 9,9,9,9,*,2,= -> error=1, display FFFF; then digit -> unchanged; then CE -> display 0000, error=0.
REQ-037 SHALL cover: 1,2,3,4,5 -> display 1234; 0,0,7 -> display 0007.
REQ-038 SHALL cover: 2,+,3,=,=,= -> display 0005, 0008, 0011; key strobes while busy leave state unchanged.
REQ-039 SHALL cover: reset_in asserted mid-CALC -> next cycle state=NUM_INIT, busy=0, display 0000.

Source files
------------

// File: rtl/calc_fsm_param_pkg.sv
// Shared constants for the keypad calculator: key codes, operator and state encodings,
// and the helpers that size operands from the digit count.
package calc_fsm_param_pkg;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_ASS  = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        NUM_INIT = 3'd0,
        LHS      = 3'd1,
        NUM_RHS  = 3'd2,
        RHS      = 3'd3,
        CALC     = 3'd4,
        RESULT   = 3'd5,
        ERR      = 3'd6
    } state_t;

    // Largest magnitude representable with the given number of decimal digits.
    function automatic int unsigned max_value(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    // Two's-complement width holding +/- max_value.
    function automatic int unsigned operand_width(input int unsigned digits);
        return $clog2(max_value(digits) + 1) + 1;
    endfunction

    function automatic logic key_is_digit(input logic [3:0] k);
        return (k >= KEY_0) && (k <= KEY_9);
    endfunction

    function automatic op_t key_to_op(input logic [3:0] k);
        case (k)
            KEY_A:   return OP_ADD;
            KEY_B:   return OP_SUB;
            KEY_C:   return OP_MUL;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/calc_fsm_param_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, done pulses after exactly
// operand_width(DIGITS) cycles counted from the start strobe.
module bin2bcd_seq
    import calc_fsm_param_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_in,
    input  logic                                 start,
    input  logic [operand_width(DIGITS)-1:0]     bin,
    output logic                                 done,
    output logic [4*DIGITS-1:0]                  bcd
);

    localparam int unsigned BW    = operand_width(DIGITS);
    localparam int unsigned DW    = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BW + 1);

    logic [BW-1:0]    bin_q;
    logic [DW-1:0]    bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    // Add-3 correction on every digit >= 5, then shift in the next binary bit.
    function automatic logic [DW-1:0] dabble_step(input logic [DW-1:0] cur, input logic msb);
        logic [DW-1:0] adj;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj[4*i +: 4] = (cur[4*i +: 4] >= 4'd5) ? cur[4*i +: 4] + 4'd3 : cur[4*i +: 4];
        end
        return {adj[DW-2:0], msb};
    endfunction

    // The start edge performs the first shift so the whole conversion spans BW edges.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                bcd_q <= dabble_step('0, bin[BW-1]);
                bin_q <= {bin[BW-2:0], 1'b0};
                cnt_q <= CNT_W'(BW - 1);
            end else if (cnt_q != '0) begin
                bcd_q <= dabble_step(bcd_q, bin_q[BW-1]);
                bin_q <= {bin_q[BW-2:0], 1'b0};
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/calc_fsm_param.sv
// Keypad calculator: digit entry, add/subtract/multiply with chaining and repeat-equals,
// bounded DIGITS-digit signed results shown in BCD.
module calc_fsm_param
    import calc_fsm_param_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  key_pressed,
    input  logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   display_bcd,
    output logic                  negative,
    output logic                  error,
    output logic                  busy,
    output logic [2:0]            state_out
);

    localparam int unsigned MAXV = max_value(DIGITS);
    localparam int unsigned BW   = operand_width(DIGITS);
    localparam int unsigned RW   = 2 * BW;
    localparam int unsigned DW   = 4 * DIGITS;
    localparam int unsigned CW   = $clog2(DIGITS + 1);

    typedef struct packed {
        logic [BW-1:0] val;
        logic [DW-1:0] bcd;
        logic [CW-1:0] cnt;
    } operand_t;

    state_t   state_q, state_d;
    operand_t lhs_q, lhs_d, rhs_q, rhs_d, res_q, res_d;
    op_t      op_q, op_d, pend_op_q, pend_op_d;
    logic     chain_q, chain_d;
    logic     phase_q, phase_d;
    logic     conv_start_c;
    logic     conv_done;
    logic [DW-1:0] conv_bcd;
    logic [DW-1:0] disp_d;
    logic          neg_d;

    logic        key_digit_c, key_eq_c, key_ce_c, key_op_valid_c;
    op_t         key_op_c;

    logic signed [RW-1:0] a_w, b_w, r_w;
    logic        [RW-1:0] r_mag;
    logic                 r_ovf;

    function automatic operand_t fresh_digit(input logic [3:0] d);
        operand_t o;
        o.val = BW'(d);
        o.bcd = DW'(d);
        o.cnt = (d != 4'd0) ? CW'(1) : '0;
        return o;
    endfunction

    // Append a digit unless full; a zero typed into an empty operand is not counted.
    function automatic operand_t append_digit(input operand_t o, input logic [3:0] d);
        operand_t n;
        n = o;
        if (o.cnt < CW'(DIGITS) && !(o.cnt == '0 && d == 4'd0)) begin
            n.val = o.val * BW'(10) + BW'(d);
            n.bcd = {o.bcd[DW-5:0], d};
            n.cnt = o.cnt + CW'(1);
        end
        return n;
    endfunction

    assign key_digit_c    = key_is_digit(key_code);
    assign key_op_c       = key_to_op(key_code);
    assign key_op_valid_c = (key_op_c != OP_NONE);
    assign key_eq_c       = (key_code == KEY_HASH);
    assign key_ce_c       = (key_code == KEY_ASS);

    // Operands are stable throughout CALC, so the product/sum stays valid until completion.
    always_comb begin
        a_w = {{BW{lhs_q.val[BW-1]}}, lhs_q.val};
        b_w = {{BW{rhs_q.val[BW-1]}}, rhs_q.val};
        case (op_q)
            OP_ADD:  r_w = a_w + b_w;
            OP_SUB:  r_w = a_w - b_w;
            OP_MUL:  r_w = a_w * b_w;
            default: r_w = a_w;
        endcase
        r_mag = r_w[RW-1] ? RW'(-r_w) : RW'(r_w);
        r_ovf = (r_mag > RW'(MAXV));
    end

    bin2bcd_seq #(
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .reset_in (reset_in),
        .start    (conv_start_c),
        .bin      (BW'(r_mag)),
        .done     (conv_done),
        .bcd      (conv_bcd)
    );

    always_comb begin
        state_d      = state_q;
        lhs_d        = lhs_q;
        rhs_d        = rhs_q;
        res_d        = res_q;
        op_d         = op_q;
        pend_op_d    = pend_op_q;
        chain_d      = chain_q;
        phase_d      = phase_q;
        conv_start_c = 1'b0;

        if (state_q == CALC) begin
            // Keys (including CE) are ignored while a result is being produced.
            if (!phase_q) begin
                if (r_ovf) begin
                    state_d = ERR;
                    chain_d = 1'b0;
                end else begin
                    conv_start_c = 1'b1;
                    phase_d      = 1'b1;
                end
            end else if (conv_done) begin
                phase_d   = 1'b0;
                res_d.val = BW'(r_w);
                res_d.bcd = conv_bcd;
                res_d.cnt = CW'(DIGITS);
                if (chain_q) begin
                    state_d = NUM_RHS;
                    lhs_d   = res_d;
                    op_d    = pend_op_q;
                    chain_d = 1'b0;
                end else begin
                    state_d = RESULT;
                end
            end
        end else if (key_pressed && key_ce_c) begin
            state_d   = NUM_INIT;
            lhs_d     = '0;
            rhs_d     = '0;
            res_d     = '0;
            op_d      = OP_NONE;
            pend_op_d = OP_NONE;
            chain_d   = 1'b0;
            phase_d   = 1'b0;
        end else if (key_pressed) begin
            case (state_q)
                NUM_INIT: begin
                    if (key_digit_c) begin
                        lhs_d   = fresh_digit(key_code);
                        state_d = LHS;
                    end
                end
                LHS: begin
                    if (key_digit_c) begin
                        lhs_d = append_digit(lhs_q, key_code);
                    end else if (key_op_valid_c) begin
                        op_d    = key_op_c;
                        state_d = NUM_RHS;
                    end else if (key_eq_c) begin
                        res_d   = lhs_q;
                        state_d = RESULT;
                    end
                end
                NUM_RHS: begin
                    if (key_digit_c) begin
                        rhs_d   = fresh_digit(key_code);
                        state_d = RHS;
                    end else if (key_op_valid_c) begin
                        op_d = key_op_c;
                    end else if (key_eq_c) begin
                        res_d   = lhs_q;
                        state_d = RESULT;
                    end
                end
                RHS: begin
                    if (key_digit_c) begin
                        rhs_d = append_digit(rhs_q, key_code);
                    end else if (key_op_valid_c) begin
                        pend_op_d = key_op_c;
                        chain_d   = 1'b1;
                        state_d   = CALC;
                    end else if (key_eq_c) begin
                        chain_d = 1'b0;
                        state_d = CALC;
                    end
                end
                RESULT: begin
                    if (key_digit_c) begin
                        lhs_d   = fresh_digit(key_code);
                        rhs_d   = '0;
                        op_d    = OP_NONE;
                        state_d = LHS;
                    end else if (key_op_valid_c) begin
                        lhs_d   = res_q;
                        op_d    = key_op_c;
                        state_d = NUM_RHS;
                    end else if (key_eq_c) begin
                        lhs_d   = res_q;
                        chain_d = 1'b0;
                        state_d = CALC;
                    end
                end
                default: ;
            endcase
        end

        // Display follows the operand that is active in the state being entered.
        case (state_d)
            NUM_INIT, LHS, NUM_RHS: disp_d = lhs_d.bcd;
            RHS:                    disp_d = rhs_d.bcd;
            RESULT:                 disp_d = res_d.bcd;
            ERR:                    disp_d = '1;
            default:                disp_d = display_bcd;
        endcase
        neg_d = (state_d == RESULT) && res_d.val[BW-1];
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q     <= NUM_INIT;
            lhs_q       <= '0;
            rhs_q       <= '0;
            res_q       <= '0;
            op_q        <= OP_NONE;
            pend_op_q   <= OP_NONE;
            chain_q     <= 1'b0;
            phase_q     <= 1'b0;
            display_bcd <= '0;
            negative    <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
            state_out   <= NUM_INIT;
        end else begin
            state_q     <= state_d;
            lhs_q       <= lhs_d;
            rhs_q       <= rhs_d;
            res_q       <= res_d;
            op_q        <= op_d;
            pend_op_q   <= pend_op_d;
            chain_q     <= chain_d;
            phase_q     <= phase_d;
            display_bcd <= disp_d;
            negative    <= neg_d;
            error       <= (state_d == ERR);
            busy        <= (state_d == CALC);
            state_out   <= state_d;
        end
    end

endmodule

// File: tb/tb_calc_fsm_param.sv
// Directed bench for calc_fsm_param (DIGITS=4): key sequences with hand-computed displays.
module tb_calc_fsm_param;
    import calc_fsm_param_pkg::*;

    localparam int BW_T = 15;

    logic        clk;
    logic        reset_in;
    logic        key_pressed;
    logic [3:0]  key_code;
    logic [15:0] display_bcd;
    logic        negative;
    logic        error;
    logic        busy;
    logic [2:0]  state_out;

    int checks;
    int failures;
    int nbusy;

    calc_fsm_param #(
        .DIGITS (4)
    ) dut (
        .clk         (clk),
        .reset_in    (reset_in),
        .key_pressed (key_pressed),
        .key_code    (key_code),
        .display_bcd (display_bcd),
        .negative    (negative),
        .error       (error),
        .busy        (busy),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic press_key(input logic [3:0] k);
        @(negedge clk);
        key_pressed = 1'b1;
        key_code    = k;
        @(negedge clk);
        key_pressed = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check_eq("busy_timeout", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks      = 0;
        failures    = 0;
        reset_in    = 1'b1;
        key_pressed = 1'b0;
        key_code    = 4'h0;
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        check_eq("rst_disp", 32'(display_bcd), 32'h0000);
        check_eq("rst_neg", 32'(negative), 0);
        check_eq("rst_err", 32'(error), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_state", 32'(state_out), 32'(NUM_INIT));

        // 12 + 34
        press_key(KEY_1); press_key(KEY_2);
        check_eq("lhs12", 32'(display_bcd), 32'h0012);
        press_key(KEY_D);
        check_eq("keyd_ignored", 32'(display_bcd), 32'h0012);
        check_eq("keyd_state", 32'(state_out), 32'(LHS));
        press_key(KEY_A);
        check_eq("numrhs_state", 32'(state_out), 32'(NUM_RHS));
        press_key(KEY_3); press_key(KEY_4);
        check_eq("rhs34", 32'(display_bcd), 32'h0034);
        press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("add_busy_cycles", 32'(nbusy), 32'(BW_T + 1));
        check_eq("add_disp", 32'(display_bcd), 32'h0046);
        check_eq("add_neg", 32'(negative), 0);
        check_eq("add_state", 32'(state_out), 32'(RESULT));

        // 5 - 9 then + 10
        press_key(KEY_5); press_key(KEY_B); press_key(KEY_9); press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("sub_disp", 32'(display_bcd), 32'h0004);
        check_eq("sub_neg", 32'(negative), 1);
        press_key(KEY_A);
        check_eq("neg_lhs_noneg", 32'(negative), 0);
        press_key(KEY_1); press_key(KEY_0); press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("negadd_disp", 32'(display_bcd), 32'h0006);
        check_eq("negadd_neg", 32'(negative), 0);

        // 9999 * 2 overflows
        press_key(KEY_9); press_key(KEY_9); press_key(KEY_9); press_key(KEY_9);
        press_key(KEY_C); press_key(KEY_2); press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("ovf_busy_cycles", 32'(nbusy), 1);
        check_eq("ovf_err", 32'(error), 1);
        check_eq("ovf_disp", 32'(display_bcd), 32'hFFFF);
        press_key(KEY_6);
        check_eq("err_digit_disp", 32'(display_bcd), 32'hFFFF);
        check_eq("err_digit_state", 32'(state_out), 32'(ERR));
        press_key(KEY_ASS);
        check_eq("ce_disp", 32'(display_bcd), 32'h0000);
        check_eq("ce_err", 32'(error), 0);
        check_eq("ce_state", 32'(state_out), 32'(NUM_INIT));

        // digit limit and leading zeros
        press_key(KEY_1); press_key(KEY_2); press_key(KEY_3); press_key(KEY_4); press_key(KEY_5);
        check_eq("digit_limit", 32'(display_bcd), 32'h1234);
        press_key(KEY_ASS);
        press_key(KEY_0); press_key(KEY_0); press_key(KEY_7);
        check_eq("lead_zero", 32'(display_bcd), 32'h0007);
        press_key(KEY_8); press_key(KEY_1); press_key(KEY_2); press_key(KEY_3);
        check_eq("lead_zero_limit", 32'(display_bcd), 32'h7812);

        // 2 + 3 = = =, strobes while busy ignored
        press_key(KEY_ASS);
        press_key(KEY_2); press_key(KEY_A); press_key(KEY_3); press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("rep1", 32'(display_bcd), 32'h0005);
        press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("rep2", 32'(display_bcd), 32'h0008);
        press_key(KEY_HASH);
        press_key(KEY_ASS);
        check_eq("busy_ce_state", 32'(state_out), 32'(CALC));
        press_key(KEY_7);
        check_eq("busy_digit_state", 32'(state_out), 32'(CALC));
        wait_idle(nbusy);
        check_eq("rep3", 32'(display_bcd), 32'h0011);

        // operator chaining: 2 + 3 + 4 =
        press_key(KEY_ASS);
        press_key(KEY_2); press_key(KEY_A); press_key(KEY_3); press_key(KEY_A);
        wait_idle(nbusy);
        check_eq("chain_state", 32'(state_out), 32'(NUM_RHS));
        check_eq("chain_disp", 32'(display_bcd), 32'h0005);
        press_key(KEY_4); press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("chain_result", 32'(display_bcd), 32'h0009);

        // reset during conversion
        press_key(KEY_ASS);
        press_key(KEY_1); press_key(KEY_A); press_key(KEY_2); press_key(KEY_HASH);
        repeat (3) @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        check_eq("abort_state", 32'(state_out), 32'(NUM_INIT));
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_disp", 32'(display_bcd), 32'h0000);
        reset_in = 1'b0;
        press_key(KEY_3); press_key(KEY_C); press_key(KEY_4); press_key(KEY_HASH);
        wait_idle(nbusy);
        check_eq("post_abort_mul", 32'(display_bcd), 32'h0012);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
